// File: rtl/mult_fu_if.sv
// Issue, branch-update and CDB signals of the multiply unit.
// master = issue stage / CDB arbiter side, slave = the multiply unit.
interface mult_fu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int BM_W  = 4
);
  logic             in_valid;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [1:0]       in_func;
  logic [TAG_W-1:0] in_tag;
  logic [BM_W-1:0]  in_b_mask;
  logic             in_ready;
  logic             br_squash;
  logic             br_resolve;
  logic [BM_W-1:0]  br_id;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;

  modport master (
    output in_valid, in_rs1, in_rs2, in_func, in_tag, in_b_mask,
    output br_squash, br_resolve, br_id, cdb_grant,
    input  in_ready, cdb_req, cdb_tag, cdb_value
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_func, in_tag, in_b_mask,
    input  br_squash, br_resolve, br_id, cdb_grant,
    output in_ready, cdb_req, cdb_tag, cdb_value
  );
endinterface

// File: rtl/mult_fu.sv
// STAGES-deep shift-and-add multiplier with branch squash/resolve tracking;
// the whole pipe freezes while a finished result waits for its CDB grant.
module mult_fu #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6,
  parameter int BM_W   = 4
) (
  input logic      clock,
  input logic      reset,
  mult_fu_if.slave fu
);
  localparam int CH = XLEN / STAGES;
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    F_MUL    = 2'd0,
    F_MULH   = 2'd1,
    F_MULHSU = 2'd2,
    F_MULHU  = 2'd3
  } func_e;

  typedef struct packed {
    logic             valid;
    func_e            func;
    logic [TAG_W-1:0] tag;
    logic [BM_W-1:0]  b_mask;
    logic [PW-1:0]    mcand;
    logic [XLEN-1:0]  mplier;
    logic [PW-1:0]    psum;
  } stage_t;

  stage_t r_stage [STAGES];
  stage_t w_src   [STAGES];
  stage_t w_next  [STAGES];
  stage_t w_entry;
  logic   w_stall;
  logic   w_rs1_signed;

  function automatic stage_t add_chunk(input stage_t s);
    stage_t o;
    o = s;
    for (int j = 0; j < CH; j++) begin
      if (s.mplier[j]) o.psum = o.psum + (s.mcand << j);
    end
    o.mcand  = s.mcand << CH;
    o.mplier = s.mplier >> CH;
    return o;
  endfunction

  assign w_stall      = r_stage[STAGES-1].valid && !fu.cdb_grant;
  assign w_rs1_signed = (fu.in_func == F_MULH) || (fu.in_func == F_MULHSU);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_entry        = '0;
    w_entry.valid  = fu.in_valid && !w_stall;
    w_entry.func   = func_e'(fu.in_func);
    w_entry.tag    = fu.in_tag;
    w_entry.b_mask = fu.in_b_mask;
    w_entry.mcand  = {{XLEN{w_rs1_signed && fu.in_rs1[XLEN-1]}}, fu.in_rs1};
    w_entry.mplier = fu.in_rs2;
    // rs2 is always walked as unsigned; a negative signed rs2 owes -rs1 * 2^XLEN.
    if (fu.in_func == F_MULH && fu.in_rs2[XLEN-1])
      w_entry.psum = '0 - (w_entry.mcand << XLEN);
  end

  always_comb begin
    w_src[0] = w_entry;
    for (int k = 1; k < STAGES; k++) w_src[k] = r_stage[k-1];
  end

  // Squash and resolve act on whatever each stage will hold next, stalled or not.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_next[k] = w_stall ? r_stage[k] : add_chunk(w_src[k]);
      if (fu.br_squash && |(w_next[k].b_mask & fu.br_id)) w_next[k].valid = 1'b0;
      if (fu.br_resolve) w_next[k].b_mask = w_next[k].b_mask & ~fu.br_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: data fields are reset too, so cdb_tag/cdb_value read 0 while reset is low.
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      for (int k = 0; k < STAGES; k++) r_stage[k] <= w_next[k];
    end
  end

  assign fu.in_ready  = !w_stall;
  assign fu.cdb_req   = r_stage[STAGES-1].valid;
  assign fu.cdb_tag   = r_stage[STAGES-1].tag;
  assign fu.cdb_value = (r_stage[STAGES-1].func == F_MUL) ? r_stage[STAGES-1].psum[XLEN-1:0]
                                                          : r_stage[STAGES-1].psum[PW-1:XLEN];
endmodule

// File: tb/tb_mult_fu.sv
// Directed and random stimulus for mult_fu, checked against an in-order
// queue of expected results computed with plain 64-bit arithmetic.
module tb_mult_fu;
  localparam int XLEN = 32, STAGES = 4, TAG_W = 6, BM_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_fu_if #(.XLEN(XLEN), .TAG_W(TAG_W), .BM_W(BM_W)) bus ();

  mult_fu #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BM_W(BM_W)) dut (
    .clock (clock),
    .reset (reset),
    .fu    (bus.slave)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
    logic [BM_W-1:0]  mask;
    int               acc;
    int               first;
  } exp_t;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] got_tag[$];
  logic [31:0]      got_val[$];
  int n_checks = 0, n_err = 0, cyc = 0, last_lat = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     a_s, a_u, b_s, b_u;
    logic [63:0] p;
    a_s = longint'(signed'(a));
    b_s = longint'(signed'(b));
    a_u = longint'(a);
    b_u = longint'(b);
    case (f)
      2'd0:    begin p = a_u * b_u; return p[31:0];  end
      2'd1:    begin p = a_s * b_s; return p[63:32]; end
      2'd2:    begin p = a_s * b_u; return p[63:32]; end
      default: begin p = a_u * b_u; return p[63:32]; end
    endcase
  endfunction

  // Evaluates the current cycle mid-period and updates the expectation queue.
  task automatic scoreboard();
    exp_t e;
    check("in_ready", 64'(bus.in_ready), 64'(!(bus.cdb_req && !bus.cdb_grant)));
    if (bus.cdb_req) begin
      check("req_has_op", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        if (exp_q[0].first < 0) exp_q[0].first = cyc;
        check("cdb_tag", 64'(bus.cdb_tag), 64'(exp_q[0].tag));
        check("cdb_value", 64'(bus.cdb_value), 64'(exp_q[0].val));
        if (bus.cdb_grant) begin
          last_lat = exp_q[0].first - exp_q[0].acc;
          got_tag.push_back(bus.cdb_tag);
          got_val.push_back(bus.cdb_value);
          void'(exp_q.pop_front());
        end
      end
    end
    if (bus.br_squash)
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if ((exp_q[i].mask & bus.br_id) != '0) exp_q.delete(i);
    if (bus.br_resolve)
      foreach (exp_q[i]) exp_q[i].mask = exp_q[i].mask & ~bus.br_id;
    if (bus.in_valid && bus.in_ready && !(bus.br_squash && (bus.in_b_mask & bus.br_id) != '0)) begin
      e.tag   = bus.in_tag;
      e.val   = ref_mul(bus.in_func, bus.in_rs1, bus.in_rs2);
      e.mask  = bus.br_resolve ? (bus.in_b_mask & ~bus.br_id) : bus.in_b_mask;
      e.acc   = cyc;
      e.first = -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    scoreboard();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.br_squash  = 1'b0;
    bus.br_resolve = 1'b0;
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input logic [BM_W-1:0] m);
    bus.in_valid  = 1'b1;
    bus.in_func   = f;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_tag    = t;
    bus.in_b_mask = m;
    cycle();
    idle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.cdb_req) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!bus.cdb_req && n < budget) begin
      cycle();
      n++;
    end
    check("req_seen", 64'(bus.cdb_req), 64'd1);
  endtask

  task automatic clear_log();
    got_tag.delete();
    got_val.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    idle();
    bus.in_func   = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.in_b_mask = '0;
    bus.br_id     = '0;
    bus.cdb_grant = 1'b0;

    // Reset state.
    #12;
    check("rst_req", 64'(bus.cdb_req), 64'd0);
    check("rst_tag", 64'(bus.cdb_tag), 64'd0);
    check("rst_value", 64'(bus.cdb_value), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);

    // MUL 7 x -3 issued on the first edge after reset release.
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.cdb_grant = 1'b1;
    clear_log();
    issue(2'd0, 32'd7, 32'hFFFF_FFFD, 6'd5, 4'b0000);
    drain(20);
    check("t1_count", 64'(got_val.size()), 64'd1);
    check("t1_value", 64'(got_val[0]), 64'hFFFF_FFEB);
    check("t1_tag", 64'(got_tag[0]), 64'd5);
    check("t1_latency", 64'(last_lat), 64'd4);

    // High-half variants and zero operands.
    clear_log();
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd1, '0);
    issue(2'd3, 32'h8000_0000, 32'h8000_0000, 6'd2, '0);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, '0);
    issue(2'd1, 32'h0,         32'hDEAD_BEEF, 6'd4, '0);
    issue(2'd2, 32'h1234_5678, 32'h0,         6'd5, '0);
    issue(2'd0, 32'hFFFF_FFFF, 32'h0,         6'd6, '0);
    drain(20);
    check("t2_count", 64'(got_val.size()), 64'd6);
    check("t2_mulh", 64'(got_val[0]), 64'h4000_0000);
    check("t2_mulhu", 64'(got_val[1]), 64'h4000_0000);
    check("t2_mulhsu", 64'(got_val[2]), 64'hFFFF_FFFF);
    check("t2_zero_rs1", 64'(got_val[3]), 64'h0);
    check("t2_zero_rs2", 64'(got_val[4]), 64'h0);
    check("t2_zero_mul", 64'(got_val[5]), 64'h0);

    // Four back-to-back ops with the grant withheld for 3 cycles.
    clear_log();
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(2'd0, 32'(i + 3), 32'(i * 11 + 5), 6'(i + 1), '0);
    wait_req(10);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_ready", 64'(bus.in_ready), 64'd0);
      cycle();
    end
    bus.cdb_grant = 1'b1;
    drain(20);
    check("t3_count", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t3_order", 64'(got_tag[i]), 64'(i + 1));

    // Squash removes only the op depending on branch 0001.
    clear_log();
    issue(2'd0, 32'd9, 32'd9, 6'd10, 4'b0001);
    issue(2'd0, 32'd8, 32'd8, 6'd11, 4'b0010);
    issue(2'd0, 32'd7, 32'd7, 6'd12, 4'b0000);
    bus.br_squash = 1'b1;
    bus.br_id     = 4'b0001;
    cycle();
    idle();
    drain(20);
    check("t4_count", 64'(got_tag.size()), 64'd2);
    check("t4_first", 64'(got_tag[0]), 64'd11);
    check("t4_second", 64'(got_tag[1]), 64'd12);

    // Resolve while stalled at the output, then a squash of the same id.
    clear_log();
    bus.cdb_grant = 1'b0;
    issue(2'd3, 32'hCAFE_F00D, 32'h1234_5678, 6'd20, 4'b0100);
    wait_req(10);
    cycle();
    cycle();
    bus.br_resolve = 1'b1;
    bus.br_id      = 4'b0100;
    cycle();
    idle();
    bus.br_squash = 1'b1;
    cycle();
    idle();
    check("t5_held_req", 64'(bus.cdb_req), 64'd1);
    check("t5_held_tag", 64'(bus.cdb_tag), 64'd20);
    bus.cdb_grant = 1'b1;
    drain(20);
    check("t5_count", 64'(got_tag.size()), 64'd1);
    check("t5_tag", 64'(got_tag[0]), 64'd20);

    // Reset with three ops in flight.
    clear_log();
    issue(2'd0, 32'd2, 32'd3, 6'd30, '0);
    issue(2'd0, 32'd4, 32'd5, 6'd31, '0);
    issue(2'd0, 32'd6, 32'd7, 6'd32, '0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_req", 64'(bus.cdb_req), 64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd1);
    check("t6_rst_tag", 64'(bus.cdb_tag), 64'd0);
    check("t6_rst_value", 64'(bus.cdb_value), 64'd0);
    cycle();
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("t6_no_bcast", 64'(got_tag.size()), 64'd0);
    issue(2'd0, 32'd12, 32'd12, 6'd33, '0);
    drain(20);
    check("t6_new_count", 64'(got_val.size()), 64'd1);
    check("t6_new_value", 64'(got_val[0]), 64'd144);
    check("t6_new_latency", 64'(last_lat), 64'd4);

    // Random traffic with random grants, squashes and resolves.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 1) == 1);
      bus.in_func    = 2'($urandom_range(0, 3));
      bus.in_rs1     = pick();
      bus.in_rs2     = pick();
      bus.in_tag     = TAG_W'(i);
      bus.in_b_mask  = BM_W'($urandom);
      bus.cdb_grant  = ($urandom_range(0, 9) < 7);
      sel            = $urandom_range(0, 19);
      bus.br_squash  = (sel == 0);
      bus.br_resolve = (sel == 1);
      bus.br_id      = BM_W'(1 << $urandom_range(0, BM_W - 1));
      cycle();
    end
    idle();
    bus.cdb_grant = 1'b1;
    drain(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
